// File: rtl/program_loader.sv
// Boot loader: frames a UART byte stream into program memory writes, checks an XOR
// checksum and holds the CPU in reset until a clean image is present.
module program_loader #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          BOOT_WAIT      = 1'b0,
  parameter int unsigned XLEN_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [XLEN_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           byte_count
);

  localparam int unsigned ADDR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                  state_q, state_n;
  logic [15:0]             len_q, len_n;
  logic [15:0]             cnt_q, cnt_n;
  logic [7:0]              chk_q, chk_n;
  logic [TMR_W-1:0]        tmr_q, tmr_n;
  logic                    we_q, we_n;
  logic [XLEN_WIDTH-1:0]   waddr_q, waddr_n;
  logic [7:0]              wdata_q, wdata_n;
  logic                    hold_q, hold_n;
  logic                    done_q, done_n;
  logic                    err_q, err_n;
  logic                    active;
  logic                    expired;

  // The loader never back-pressures the receiver.
  assign rx_ready   = 1'b1;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign byte_count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= BOOT_WAIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      cnt_q   <= cnt_n;
      chk_q   <= chk_n;
      tmr_q   <= tmr_n;
      we_q    <= we_n;
      waddr_q <= waddr_n;
      wdata_q <= wdata_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    chk_n   = chk_q;
    tmr_n   = '0;
    we_n    = 1'b0;
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;

    active  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
              (state_q == DATA)   || (state_q == CHECK);
    // A byte arriving on the expiry cycle wins over the timeout.
    expired = active && !rx_valid && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    if (active && !rx_valid) begin
      tmr_n = tmr_q + TMR_W'(1);
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (state_q == DONE) begin
          hold_n = 1'b0;
        end
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_n = LEN_LO;
          hold_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = 1'b0;
          cnt_n   = '0;
          chk_n   = '0;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_n[7:0] = rx_data;
          state_n    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_n[15:8] = rx_data;
          if (32'({rx_data, len_q[7:0]}) > MEM_BYTES) begin
            state_n = ERROR;
            err_n   = 1'b1;
          end else if ({rx_data, len_q[7:0]} == 16'd0) begin
            state_n = CHECK;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          we_n    = 1'b1;
          waddr_n = XLEN_WIDTH'(cnt_q[ADDR_W-1:0]);
          wdata_n = rx_data;
          chk_n   = chk_q ^ rx_data;
          cnt_n   = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == len_q) begin
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ERROR;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (expired) begin
      state_n = ERROR;
      err_n   = 1'b1;
    end
  end

endmodule
